commutator_out: RTL
===================

COMMUTATOR_OUT -- requirements
Module: commutator_out

Interface
REQ-001 SHALL have parameter gp_data_width, default 8: bit-width of each sample, signed.
REQ-002 SHALL have parameter gp_nr_phases, default 4: number of polyphase branches serialized; legal range 2..256.
REQ-003 SHALL have port i_clk  input  1  rising-edge clock, sole clock.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_ena  input  1  synchronous active-high clock enable; all state frozen when low.
REQ-006 SHALL have port i_load  input  1  request to capture one parallel frame.
REQ-007 SHALL have port i_data  input  gp_nr_phases*gp_data_width  parallel frame; phase p at bits [(p+1)*W-1 -: W].
REQ-008 SHALL have port o_ready  output  1  frame can be accepted this cycle.
REQ-009 SHALL have port o_data  output  gp_data_width  current serialized sample.
REQ-010 SHALL have port o_valid  output  1  o_data holds a valid sample.
REQ-011 SHALL have port o_phase  output  max(1,$clog2(gp_nr_phases))  phase index of o_data.
REQ-012 SHALL have port o_overrun  output  1  sticky flag: a load was rejected.

Function
REQ-013 SHALL implement two states: IDLE (no frame pending) and SHIFT (emitting a frame).
REQ-014 SHALL accept a frame when i_ena && i_load && o_ready at a rising edge.
REQ-015 o_ready SHALL be 1 in IDLE, and in SHIFT only when o_phase == gp_nr_phases-1; it is decoded from registers only, never from inputs.
REQ-016 On acceptance, the next cycle SHALL show o_valid=1, o_phase=0, o_data=phase-0 slice; latency exactly one enabled edge.
REQ-017 In SHIFT, each enabled edge SHALL advance o_phase by 1 and present the matching slice of the captured frame.
REQ-018 Acceptance during the last phase SHALL start the next frame at phase 0 with no bubble (back-to-back).
REQ-019 After phase gp_nr_phases-1 without acceptance, the next enabled edge SHALL go to IDLE, o_valid=0; o_data and o_phase hold their last values.
REQ-020 i_load while i_ena=1 and o_ready=0 SHALL be ignored, leave the in-flight frame untouched, and set o_overrun.
REQ-021 o_overrun SHALL remain 1 until reset.
REQ-022 With i_ena=0, i_load SHALL be ignored and no output may change; o_overrun shall not be set.
REQ-023 The captured frame SHALL be held in an internal register, so i_data may change after acceptance.
REQ-024 The phase counter SHALL wrap from gp_nr_phases-1 to 0 on back-to-back loads, including non-power-of-two gp_nr_phases.

Reset
REQ-025 i_rst=1 SHALL asynchronously force IDLE, o_valid=0, o_phase=0, o_data=0, o_overrun=0, frame register=0, hence o_ready=1.
REQ-026 Reset asserted mid-frame SHALL discard remaining phases; after release, the first enabled edge behaves as from IDLE.

Structure
REQ-027 State encoding and counter width SHALL be module-local localparams; no shared package needed.
REQ-028 The frame register SHALL reuse the codebase's existing dff sub-module (parameter gp_data_width = gp_nr_phases*gp_data_width), with its reset polarity adapted at instantiation.
REQ-029 The phase counter, FSM and output mux SHALL be in a single sequential process plus combinational slice select.

Verification
REQ-030 Single frame, N=4, W=8, i_data=0x04030201, i_ena=1: o_data 0x01,0x02,0x03,0x04 on cycles 1..4, o_phase 0..3, o_valid low on cycle 5.
REQ-031 Back-to-back: second frame 0x08070605 loaded while o_phase=3 -> continuous 01,02,03,04,05,06,07,08, o_valid never drops.
REQ-032 Overrun: i_load at o_phase=1 -> frame continues unchanged, o_overrun=1 and stays 1 after IDLE.
REQ-033 Enable gating: i_ena toggling 1,0,1,0 during a frame -> o_phase advances only on enabled edges; i_load with i_ena=0 and o_ready=0 leaves o_overrun=0.
REQ-034 Reset mid-frame at o_phase=2 -> immediate o_valid=0, o_data=0, o_ready=1; new frame after release starts at phase 0.
REQ-035 N=3 back-to-back for 4 frames -> o_phase sequence 0,1,2,0,1,2,... with no invalid code 3.

Source files
------------

// File: rtl/commutator_out_pkg.sv
// Shared helpers for the output commutator slice.
package commutator_out_pkg;

   // Width of a phase index; never narrower than one bit.
   function automatic int unsigned f_phase_width(input int unsigned nr_phases);
      return (nr_phases > 1) ? $clog2(nr_phases) : 1;
   endfunction

endpackage

// File: rtl/commutator_out_dff.sv
// Generic enabled register with asynchronous active-low reset.
module dff #(
   parameter int unsigned gp_data_width = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_ena,
   input  logic [gp_data_width-1:0] i_d,
   output logic [gp_data_width-1:0] o_q
);

   logic [gp_data_width-1:0] r_q;

   // Capture i_d on enabled edges, clear on reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_ena) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/commutator_out.sv
// Parallel-to-serial commutator: captures a frame of gp_nr_phases samples
// and emits them one per enabled clock, phase 0 first.
module commutator_out
   import commutator_out_pkg::*;
#(
   parameter int unsigned gp_data_width = 8,
   parameter int unsigned gp_nr_phases  = 4
) (
   input  logic                                    i_clk,
   input  logic                                    i_rst,
   input  logic                                    i_ena,
   input  logic                                    i_load,
   input  logic [gp_nr_phases*gp_data_width-1:0]   i_data,
   output logic                                    o_ready,
   output logic [gp_data_width-1:0]                o_data,
   output logic                                    o_valid,
   output logic [f_phase_width(gp_nr_phases)-1:0]  o_phase,
   output logic                                    o_overrun
);

   localparam int unsigned lp_phase_w = f_phase_width(gp_nr_phases);
   localparam int unsigned lp_frame_w = gp_nr_phases * gp_data_width;
   localparam logic [lp_phase_w-1:0] lp_last_phase = lp_phase_w'(gp_nr_phases - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                   r_state;
   logic [lp_phase_w-1:0]    r_phase;
   logic [gp_data_width-1:0] r_data;
   logic                     r_valid;
   logic                     r_overrun;

   logic                     w_rst_n;
   logic                     w_ready;
   logic                     w_accept;
   logic [lp_frame_w-1:0]    w_frame;
   logic [lp_frame_w-1:0]    w_sel_frame;
   logic [lp_phase_w-1:0]    w_next_phase;
   logic [gp_data_width-1:0] w_slice;

   assign w_rst_n  = ~i_rst;
   assign w_ready  = (r_state == ST_IDLE) || (r_phase == lp_last_phase);
   assign w_accept = i_ena && i_load && w_ready;

   dff #(
      .gp_data_width(lp_frame_w)
   ) u_frame_reg (
      .i_clk   (i_clk),
      .i_rst_n (w_rst_n),
      .i_ena   (w_accept),
      .i_d     (i_data),
      .o_q     (w_frame)
   );

   // Select the sample for the next phase; on acceptance the frame register
   // is still loading, so phase 0 is taken straight from i_data.
   always_comb begin
      w_sel_frame  = w_accept ? i_data : w_frame;
      w_next_phase = w_accept ? '0 : (r_phase + 1'b1);
      w_slice      = '0;
      for (int unsigned p = 0; p < gp_nr_phases; p++) begin
         if (w_next_phase == lp_phase_w'(p)) begin
            w_slice = w_sel_frame[p*gp_data_width +: gp_data_width];
         end
      end
   end

   // FSM, phase counter, registered output sample and sticky overrun flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_phase   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (i_ena) begin
         if (i_load && !w_ready) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_SHIFT;
                  r_phase <= '0;
                  r_data  <= w_slice;
                  r_valid <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (w_accept) begin
                  r_phase <= '0;
                  r_data  <= w_slice;
               end else if (r_phase == lp_last_phase) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
               end else begin
                  r_phase <= w_next_phase;
                  r_data  <= w_slice;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready   = w_ready;
   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_phase   = r_phase;
   assign o_overrun = r_overrun;

endmodule
